// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and decode helpers for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_MAX = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;
  localparam logic [3:0] OP_LT  = 4'b1010;
  localparam logic [3:0] OP_EQ  = 4'b1011;
  localparam logic [3:0] OP_NOP = 4'b1100;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  function automatic logic is_multicycle(input logic [3:0] code);
    return (code == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle between the register-read stage, the ALU and writeback.
interface alu_seq_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       code;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic [WIDTH-1:0] z_hi;
  logic             cmp_flag;
  logic             zero_flag;
  logic             carry_flag;

  modport master (
    output in_valid, code, x, y, out_ready,
    input  in_ready, out_valid, z, z_hi, cmp_flag, zero_flag, carry_flag
  );

  modport slave (
    input  in_valid, code, x, y, out_ready,
    output in_ready, out_valid, z, z_hi, cmp_flag, zero_flag, carry_flag
  );

endinterface

// File: rtl/alu_seq_multiplier.sv
// Unsigned radix-2 shift-add multiplier: one partial product per clock, full 2*WIDTH result.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_s;

  // Step control: load on start, then add/shift once per cycle until the last bit.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_s   = 1'b0;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = {(2*WIDTH){1'b0}};
      cnt_d    = {CW{1'b0}};
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q == LAST) begin
        cnt_d  = {CW{1'b0}};
        busy_d = 1'b0;
        done_s = 1'b1;
      end else begin
        cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Datapath and sequencing registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      cnt_q    <= {CW{1'b0}};
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  // The final sum is handed out combinationally so the caller registers it on the done edge.
  assign busy    = busy_q;
  assign done    = done_s;
  assign product = acc_d;

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-generic ALU: single-cycle ops register at accept, Mul iterates in seq_multiplier.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit SIGNED_CMP = 1'b0
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   z_q, z_d;
  logic [WIDTH-1:0]   z_hi_q, z_hi_d;
  logic               cmp_q, cmp_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;

  logic               in_ready_s;
  logic               accept_s;
  logic               mul_start_s;
  logic               mul_busy_s;
  logic               mul_done_s;
  logic [2*WIDTH-1:0] mul_prod_s;

  logic [WIDTH:0]     sum_s;
  logic               lt_s;
  logic               shift_oob_s;
  logic [WIDTH-1:0]   alu_z_s;
  logic               alu_cmp_s;
  logic               alu_carry_s;

  assign in_ready_s  = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept_s    = bus.in_valid && in_ready_s;
  assign sum_s       = {1'b0, bus.x} + {1'b0, bus.y};
  assign lt_s        = SIGNED_CMP ? ($signed(bus.x) < $signed(bus.y)) : (bus.x < bus.y);
  assign shift_oob_s = (bus.y >= WIDTH_V);

  // Single-cycle result and flags straight from the operand bus.
  always_comb begin
    alu_z_s     = {WIDTH{1'b0}};
    alu_cmp_s   = 1'b0;
    alu_carry_s = 1'b0;
    case (bus.code)
      OP_ADD: begin
        alu_z_s     = sum_s[WIDTH-1:0];
        alu_carry_s = sum_s[WIDTH];
      end
      OP_SUB: begin
        alu_z_s     = bus.x - bus.y;
        alu_carry_s = (bus.x < bus.y);
      end
      OP_AND: alu_z_s = bus.x & bus.y;
      OP_OR:  alu_z_s = bus.x | bus.y;
      OP_XOR: alu_z_s = bus.x ^ bus.y;
      OP_NOT: alu_z_s = ~bus.x;
      OP_MAX: alu_z_s = lt_s ? bus.y : bus.x;
      OP_SHL: alu_z_s = shift_oob_s ? {WIDTH{1'b0}} : (bus.x << bus.y);
      OP_SHR: alu_z_s = shift_oob_s ? {WIDTH{1'b0}} : (bus.x >> bus.y);
      OP_LT:  alu_cmp_s = lt_s;
      OP_EQ:  alu_cmp_s = (bus.x == bus.y);
      default: begin
        // Nop codes; Mul is routed to the multiplier and never uses this result.
        alu_z_s     = {WIDTH{1'b0}};
        alu_cmp_s   = 1'b0;
        alu_carry_s = 1'b0;
      end
    endcase
  end

  // FSM next state and result-register loading.
  always_comb begin
    state_d     = state_q;
    z_d         = z_q;
    z_hi_d      = z_hi_q;
    cmp_d       = cmp_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    mul_start_s = 1'b0;
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    case (state_q)
      IDLE: begin
        if (accept_s && is_multicycle(bus.code)) begin
          mul_start_s = 1'b1;
          state_d     = MUL;
        end else if (accept_s) begin
          out_valid_d = 1'b1;
          z_d         = alu_z_s;
          z_hi_d      = {WIDTH{1'b0}};
          cmp_d       = alu_cmp_s;
          zero_d      = (alu_z_s == {WIDTH{1'b0}});
          carry_d     = alu_carry_s;
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        if (mul_done_s) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          z_d         = mul_prod_s[WIDTH-1:0];
          z_hi_d      = mul_prod_s[2*WIDTH-1:WIDTH];
          cmp_d       = 1'b0;
          zero_d      = (mul_prod_s[WIDTH-1:0] == {WIDTH{1'b0}});
          carry_d     = 1'b0;
        end else if (!mul_busy_s) begin
          // Multiplier idle without a done pulse: drop back rather than hang the pipe.
          state_d = IDLE;
        end else begin
          state_d = MUL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      z_q         <= {WIDTH{1'b0}};
      z_hi_q      <= {WIDTH{1'b0}};
      cmp_q       <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
      z_hi_q      <= z_hi_d;
      cmp_q       <= cmp_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
    end
  end

  seq_multiplier #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start_s),
    .a       (bus.x),
    .b       (bus.y),
    .busy    (mul_busy_s),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_q;
  assign bus.z          = z_q;
  assign bus.z_hi       = z_hi_q;
  assign bus.cmp_flag   = cmp_q;
  assign bus.zero_flag  = zero_q;
  assign bus.carry_flag = carry_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: unsigned (dut0) and signed-compare (dut1) instances share one stimulus stream.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         in_valid_t;
  logic         out_ready_t;
  logic [3:0]   code_t;
  logic [W-1:0] x_t;
  logic [W-1:0] y_t;
  int           total = 0;
  int           bad   = 0;

  alu_seq_if #(.WIDTH(W)) bus0 ();
  alu_seq_if #(.WIDTH(W)) bus1 ();

  assign bus0.in_valid  = in_valid_t;
  assign bus0.code      = code_t;
  assign bus0.x         = x_t;
  assign bus0.y         = y_t;
  assign bus0.out_ready = out_ready_t;
  assign bus1.in_valid  = in_valid_t;
  assign bus1.code      = code_t;
  assign bus1.x         = x_t;
  assign bus1.y         = y_t;
  assign bus1.out_ready = out_ready_t;

  alu_seq #(.WIDTH(W), .SIGNED_CMP(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  alu_seq #(.WIDTH(W), .SIGNED_CMP(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    code_t     = c;
    x_t        = a;
    y_t        = b;
    in_valid_t = 1'b1;
    tick();
    in_valid_t = 1'b0;
  endtask

  // Counts edges from just after the accept edge until out_valid, noting any in_ready high meanwhile.
  task automatic mul_wait(output int n, output int ready_seen);
    n          = 0;
    ready_seen = 0;
    code_t     = OP_ADD;
    x_t        = 32'h0000_0000;
    y_t        = 32'h0000_0000;
    while (!bus0.out_valid && n < 100) begin
      if (bus0.in_ready) ready_seen++;
      tick();
      n++;
    end
  endtask

  logic [W-1:0] bx [4] = '{32'h0000_0001, 32'hFFFF_0000, 32'hAAAA_5555, 32'h1234_5678};
  logic [W-1:0] by [4] = '{32'h0000_0003, 32'h0000_FFFF, 32'hAAAA_5555, 32'hFFFF_FFFF};
  logic [W-1:0] bz [4] = '{32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000, 32'hEDCB_A987};

  initial begin
    int n;
    int ready_seen;
    int stray;

    rst         = 1'b1;
    in_valid_t  = 1'b0;
    out_ready_t = 1'b1;
    code_t      = 4'b0000;
    x_t         = 32'h0000_0000;
    y_t         = 32'h0000_0000;
    tick();
    tick();
    chk("rst_out_valid", bus0.out_valid, 1'b0);
    chk("rst_z", bus0.z, 32'h0);
    chk("rst_z_hi", bus0.z_hi, 32'h0);
    chk("rst_flags", {bus0.cmp_flag, bus0.zero_flag, bus0.carry_flag}, 3'b000);
    chk("rst_in_ready", bus0.in_ready, 1'b1);
    rst = 1'b0;
    tick();

    // Leave a nonzero result behind, then abort a multiply partway.
    issue(OP_ADD, 32'd10, 32'd20);
    chk("pre_add_z", bus0.z, 32'd30);
    issue(OP_MUL, 32'd5, 32'd7);
    chk("mul_busy_ready", bus0.in_ready, 1'b0);
    repeat (4) tick();
    rst = 1'b1;
    #2;
    chk("midmul_rst_valid", bus0.out_valid, 1'b0);
    tick();
    rst = 1'b0;
    chk("midmul_rst_z", bus0.z, 32'h0);
    chk("midmul_rst_ready", bus0.in_ready, 1'b1);
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus0.out_valid) stray++;
      tick();
    end
    chk("midmul_no_stray", stray, 0);

    issue(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("add_valid", bus0.out_valid, 1'b1);
    chk("add_z", bus0.z, 32'h0);
    chk("add_carry", bus0.carry_flag, 1'b1);
    chk("add_zero", bus0.zero_flag, 1'b1);
    chk("add_z_hi", bus0.z_hi, 32'h0);
    tick();
    chk("add_retire", bus0.out_valid, 1'b0);

    issue(OP_SUB, 32'd3, 32'd5);
    chk("sub_z", bus0.z, 32'hFFFF_FFFE);
    chk("sub_borrow", bus0.carry_flag, 1'b1);
    chk("sub_zero", bus0.zero_flag, 1'b0);
    issue(OP_SUB, 32'd5, 32'd5);
    chk("sub_eq_flags", {bus0.zero_flag, bus0.carry_flag}, 2'b10);

    issue(OP_MUL, 32'hFFFF_FFFF, 32'h0000_0002);
    mul_wait(n, ready_seen);
    chk("mul_latency", n, 32);
    chk("mul_ready_low", ready_seen, 0);
    chk("mul_z", bus0.z, 32'hFFFF_FFFE);
    chk("mul_z_hi", bus0.z_hi, 32'h0000_0001);
    chk("mul_flags", {bus0.cmp_flag, bus0.zero_flag, bus0.carry_flag}, 3'b000);
    tick();
    issue(OP_MUL, 32'h0001_0000, 32'h0001_0000);
    mul_wait(n, ready_seen);
    chk("mul2_latency", n, 32);
    chk("mul2_z", bus0.z, 32'h0);
    chk("mul2_z_hi", bus0.z_hi, 32'h0000_0001);
    chk("mul2_zero", bus0.zero_flag, 1'b1);
    tick();

    // Backpressure: hold a result, then retire it and load the next on one edge.
    out_ready_t = 1'b0;
    issue(OP_ADD, 32'd1, 32'd2);
    chk("bp_valid", bus0.out_valid, 1'b1);
    chk("bp_z", bus0.z, 32'd3);
    chk("bp_ready", bus0.in_ready, 1'b0);
    code_t = OP_XOR;
    x_t    = 32'h1111_1111;
    y_t    = 32'h2222_2222;
    in_valid_t = 1'b1;
    tick();
    chk("bp_hold_z", bus0.z, 32'd3);
    chk("bp_hold_valid", bus0.out_valid, 1'b1);
    x_t = 32'h0F0F_0F0F;
    y_t = 32'h00FF_00FF;
    out_ready_t = 1'b1;
    #1;
    chk("bp_ready_release", bus0.in_ready, 1'b1);
    tick();
    chk("bp_swap_z", bus0.z, 32'h0FF0_0FF0);
    chk("bp_swap_valid", bus0.out_valid, 1'b1);
    for (int i = 0; i < 4; i++) begin
      x_t = bx[i];
      y_t = by[i];
      tick();
      chk($sformatf("b2b_z%0d", i), bus0.z, bz[i]);
      chk($sformatf("b2b_valid%0d", i), bus0.out_valid, 1'b1);
    end
    in_valid_t = 1'b0;
    tick();
    chk("b2b_drain", bus0.out_valid, 1'b0);

    issue(OP_LT, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("lt_unsigned_cmp", bus0.cmp_flag, 1'b0);
    chk("lt_signed_cmp", bus1.cmp_flag, 1'b1);
    chk("lt_z_zero", {bus0.z, bus0.zero_flag}, {32'h0, 1'b1});
    issue(OP_MAX, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("max_unsigned", bus0.z, 32'hFFFF_FFFF);
    chk("max_signed", bus1.z, 32'h0000_0001);
    issue(OP_SHL, 32'h0000_0001, 32'd40);
    chk("shl_oob", {bus0.z, bus0.cmp_flag, bus0.zero_flag}, {32'h0, 1'b0, 1'b1});
    issue(OP_SHL, 32'h0000_0001, 32'd32);
    chk("shl_w", bus0.z, 32'h0);
    issue(OP_SHL, 32'h0000_0001, 32'd31);
    chk("shl_31", bus0.z, 32'h8000_0000);
    issue(OP_SHR, 32'h8000_0000, 32'd31);
    chk("shr_logical", bus0.z, 32'h0000_0001);
    issue(OP_NOT, 32'h0000_FFFF, 32'h0);
    chk("not_z", bus0.z, 32'hFFFF_0000);
    issue(OP_EQ, 32'd7, 32'd7);
    chk("eq_hit", {bus0.z, bus0.cmp_flag, bus0.zero_flag}, {32'h0, 1'b1, 1'b1});
    issue(OP_EQ, 32'd7, 32'd8);
    chk("eq_miss", bus0.cmp_flag, 1'b0);
    issue(OP_AND, 32'h0000_F0F0, 32'h0000_FF00);
    chk("and_z", bus0.z, 32'h0000_F000);
    issue(OP_OR, 32'h0000_F0F0, 32'h0000_FF00);
    chk("or_z", bus0.z, 32'h0000_FFF0);
    issue(4'b1110, 32'd5, 32'd9);
    chk("nop_valid", bus0.out_valid, 1'b1);
    chk("nop_out", {bus0.z, bus0.cmp_flag, bus0.zero_flag, bus0.carry_flag}, {32'h0, 3'b010});
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
